ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/muldiv_core.sv | 32 +++
 rtl/ex_muldiv.sv | 172 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and small opcode decode helpers.
package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step on a 2*WIDTH accumulator {upper, lower}.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: upper half gathers partial sums, multiplier shifts out of lower half.
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (is_div) begin
            if (diff[WIDTH])
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            else
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then fixes signs in one cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             flush,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    assign a_neg = op_is_signed(op) & data_a[WIDTH-1];
    assign b_neg = op_is_signed(op) & data_b[WIDTH-1];
    assign a_mag = a_neg ? -data_a : data_a;
    assign b_mag = b_neg ? -data_b : data_b;

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div (op_is_div(op_q)),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (mt_hi) hi_d = data_a;
                if (mt_lo) lo_d = data_a;
                if (start && !flush) begin
                    op_d       = op;
                    cnt_d      = '0;
                    a_raw_d    = data_a;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    dbz_pend_d = op_is_div(op) && (data_b == '0);
                    if (op_is_div(op)) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_SIGN;
            end
            ST_SIGN: begin
                if (!op_is_div(op_q)) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dbz_pend_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A squash drops the operation, including a pending HI/LO write in SIGN.
        if (flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_SIGN) && !flush;
        dbz_d  = done_d && dbz_pend_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32): vector table, random ops
// against an arithmetic model, and hand sequences for flush/reset/mt corners.
module tb_ex_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    ex_muldiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .data_a(data_a), .data_b(data_b), .flush(flush),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dbz;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sbq[$];
    vec_t vecs[10];

    always @(negedge clock) if (done) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        longint      sa, sbv;
        logic [63:0] p, q, m;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r.dbz = 1'b0;
        r.hi  = '0;
        r.lo  = '0;
        case (o)
            2'b00: begin p = sa * sbv; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    r.hi = a; r.lo = '1; r.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sbv; m = sa % sbv; r.lo = q[31:0]; r.hi = m[31:0];
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Launch one op at cycle 0; xs = cycle of a redundant start, mtc = cycle of
    // a mt_hi while busy, mt0 = mt_lo of data_a alongside the start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int xs, input int mtc, input bit mt0);
        exp_t        got;
        int          cyc;
        logic [31:0] hi0;
        sbq.push_back(e);
        hi0 = hi;
        op = o; data_a = a; data_b = b; start = 1'b1; mt_lo = mt0; cyc = 0;
        do begin
            tick();
            cyc++;
            if (mt0 && cyc == 1) chk("mt_with_start_lo", lo, a);
            mt_lo  = 1'b0;
            start  = (cyc == xs);
            mt_hi  = (cyc == mtc);
            data_a = (cyc == mtc) ? 32'h12345678 : a;
            if (mtc > 0 && cyc == mtc + 1) chk("mt_busy_hi", hi, hi0);
        end while (!done && cyc < 60);
        start = 1'b0; mt_hi = 1'b0; data_a = a;
        got = sbq.pop_front();
        chk("latency", 32'(cyc), 32'd34);
        chk("hi", hi, got.hi);
        chk("lo", lo, got.lo);
        chk("dbz", {31'b0, div_by_zero}, {31'b0, got.dbz});
        tick();
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("done_after", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int          dc0;
        logic [31:0] hi0, lo0;
        exp_t        e;
        vec_t        v;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{2'b11, 32'h00000100, 32'h00000007, 32'h00000004, 32'h00000024, 1'b0};
        vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8] = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[9] = '{2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};

        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        mt_hi = 1'b1; data_a = 32'h12345678;
        tick();
        mt_hi = 1'b0;
        chk("mt_idle_hi", hi, 32'h12345678);
        chk("mt_idle_lo_kept", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz;
            run_op(v.op, v.a, v.b, e, 0, 0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), 0, 0, 1'b0);
        end

        // Redundant start at cycle 5 and mt_hi at cycle 7 while busy.
        e = model(2'b00, 32'hFFFFFFFD, 32'h00000005);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, e, 5, 7, 1'b0);

        // mt_lo together with start: write lands first, result overwrites.
        e = model(2'b01, 32'hCAFEF00D, 32'h00000002);
        run_op(2'b01, 32'hCAFEF00D, 32'h00000002, e, 0, 0, 1'b1);
        chk("mt_start_model_hi", e.hi, 32'h00000001);

        // Flush at cycle 10.
        hi0 = hi; lo0 = lo; dc0 = done_cnt;
        op = 2'b10; data_a = 32'd1000; data_b = 32'd3; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start = 1'b0;
            flush = (c == 10);
        end
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_hi", hi, hi0);
        chk("flush_lo", lo, lo0);
        repeat (40) tick();
        chk("flush_no_done", 32'(done_cnt), 32'(dc0));

        // Flush together with start in IDLE.
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'd0);

        // Reset at cycle 20 mid-operation.
        op = 2'b01; data_a = 32'd77; data_b = 32'd88; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            start = 1'b0;
            reset = (c != 20);
        end
        reset = 1'b1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        dc0 = done_cnt;
        repeat (40) tick();
        chk("midrst_no_done", 32'(done_cnt), 32'(dc0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
